// File: rtl/riscv_wb_arb_pkg.sv
// Shared RISC-V configuration macros (riscv_configs) and the
// types used by the write-back arbiter.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V
`define XLEN 32
`define WB_ST_NORM 1'b0
`define WB_ST_FORCE 1'b1
`define WB_ARB_STARVE_MAX 4
`endif

package riscv_wb_arb_pkg;

  localparam int unsigned RD_W = 5;

  localparam logic [0:0] ST_NORM  = `WB_ST_NORM;
  localparam logic [0:0] ST_FORCE = `WB_ST_FORCE;

  // One register-file write as carried by the output register bank.
  typedef struct packed {
    logic            wr_en;
    logic [RD_W-1:0] rd;
    logic [`XLEN-1:0] data;
  } wb_wr_t;

endpackage

// File: rtl/riscv_wb_arb_reg.sv
// Output register bank of the write-back arbiter: the write
// strobe reloads every cycle, address and data only on a transfer.
module riscv_wb_arb_reg
  import riscv_wb_arb_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_en,
  input  wb_wr_t i_d,
  output wb_wr_t o_q
);

  wb_wr_t r_q;

  // Strobe follows the transfer; rd/data hold when idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else begin
      r_q.wr_en <= i_d.wr_en;
      if (i_en) begin
        r_q.rd   <= i_d.rd;
        r_q.data <= i_d.data;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/riscv_wb_arb.sv
// Two-port register-file write-back arbiter: pipeline port 0 has
// priority, long-latency port 1 is force-granted when starved.
module riscv_wb_arb
  import riscv_wb_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = `WB_ARB_STARVE_MAX
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_p0_valid,
  input  logic [4:0]       i_p0_rd,
  input  logic [`XLEN-1:0] i_p0_data,
  output logic             o_p0_ready,
  input  logic             i_p1_valid,
  input  logic [4:0]       i_p1_rd,
  input  logic [`XLEN-1:0] i_p1_data,
  output logic             o_p1_ready,
  output logic             o_rf_wr_en,
  output logic [4:0]       o_rf_rd,
  output logic [`XLEN-1:0] o_rf_wr_data,
  output logic             o_p0_stall
);

  localparam logic [2:0] CNT_TRIP = 3'(STARVE_MAX - 1);

  logic [0:0] r_state;
  logic [2:0] r_cnt;

  logic       w_g0;
  logic       w_g1;
  logic       w_xfer;
  logic       w_inc;
  logic [2:0] w_cnt_nxt;
  logic [0:0] w_state_nxt;
  wb_wr_t     w_wr_d;
  wb_wr_t     w_wr_q;

  // Grant decode; nothing is granted while reset is held.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (!i_rst) begin
      unique case (r_state)
        ST_NORM: begin
          w_g0 = i_p0_valid;
          w_g1 = ~i_p0_valid & i_p1_valid;
        end
        ST_FORCE: begin
          w_g1 = i_p1_valid;
        end
        default: begin
          w_g0 = 1'b0;
          w_g1 = 1'b0;
        end
      endcase
    end
  end

  assign w_xfer    = w_g0 | w_g1;
  assign w_inc     = i_p1_valid & ~w_g1;
  assign w_cnt_nxt = w_inc ? r_cnt + 3'd1 : 3'd0;

  // Next state: trip into FORCE on the denial that reaches the
  // limit; FORCE lasts until port 1 is served or withdraws.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_NORM: begin
        if (w_inc && (r_cnt == CNT_TRIP))
          w_state_nxt = ST_FORCE;
      end
      ST_FORCE: begin
        if (w_g1 || !i_p1_valid)
          w_state_nxt = ST_NORM;
      end
      default: begin
        w_state_nxt = ST_NORM;
      end
    endcase
  end

  // Arbitration state and starvation counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_NORM;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Select the granted port's write; rd=0 still completes.
  always_comb begin
    w_wr_d.wr_en = w_xfer & (w_g0 ? (i_p0_rd != 5'd0)
                                  : (i_p1_rd != 5'd0));
    w_wr_d.rd    = w_g0 ? i_p0_rd : i_p1_rd;
    w_wr_d.data  = w_g0 ? i_p0_data : i_p1_data;
  end

  riscv_wb_arb_reg u_reg (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_xfer),
    .i_d   (w_wr_d),
    .o_q   (w_wr_q)
  );

  assign o_p0_ready   = w_g0;
  assign o_p1_ready   = w_g1;
  assign o_p0_stall   = i_p0_valid & ~w_g0;
  assign o_rf_wr_en   = w_wr_q.wr_en;
  assign o_rf_rd      = w_wr_q.rd;
  assign o_rf_wr_data = w_wr_q.data;

endmodule

// File: tb/tb_riscv_wb_arb.sv
// Self-checking bench for riscv_wb_arb: directed scenarios plus
// random traffic against a starvation-streak reference model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_wb_arb;

  localparam int SM = 4;
  localparam int XL = `XLEN;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_valid, p1_valid;
  logic [4:0]    p0_rd, p1_rd;
  logic [XL-1:0] p0_data, p1_data;
  logic          p0_ready, p1_ready;
  logic          rf_wr_en, p0_stall;
  logic [4:0]    rf_rd;
  logic [XL-1:0] rf_wr_data;

  int errors = 0;
  int checks = 0;

  // Reference model: grant intent and expected register outputs.
  bit            m_force;
  int            m_streak;
  bit            m_g0, m_g1;
  logic          m_en;
  logic [4:0]    m_rd;
  logic [XL-1:0] m_data;

  riscv_wb_arb #(.STARVE_MAX(SM)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_p0_valid   (p0_valid),
    .i_p0_rd      (p0_rd),
    .i_p0_data    (p0_data),
    .o_p0_ready   (p0_ready),
    .i_p1_valid   (p1_valid),
    .i_p1_rd      (p1_rd),
    .i_p1_data    (p1_data),
    .o_p1_ready   (p1_ready),
    .o_rf_wr_en   (rf_wr_en),
    .o_rf_rd      (rf_rd),
    .o_rf_wr_data (rf_wr_data),
    .o_p0_stall   (p0_stall)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_force  = 0;
    m_streak = 0;
    m_en     = 1'b0;
    m_rd     = '0;
    m_data   = '0;
  endtask

  // Apply inputs, let them settle, compute the model's grant.
  task automatic drive(input logic v0, input logic [4:0] r0,
                       input logic [XL-1:0] d0, input logic v1,
                       input logic [4:0] r1,
                       input logic [XL-1:0] d1);
    p0_valid = v0; p0_rd = r0; p0_data = d0;
    p1_valid = v1; p1_rd = r1; p1_data = d1;
    #1;
    m_g0 = 0;
    m_g1 = 0;
    if (!rst) begin
      if (m_force) m_g1 = v1;
      else if (v0) m_g0 = 1;
      else m_g1 = v1;
    end
  endtask

  // Clock edge: advance the model by one cycle.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (m_g0 || m_g1) begin
        m_rd   = m_g0 ? p0_rd : p1_rd;
        m_data = m_g0 ? p0_data : p1_data;
        m_en   = (m_rd != 0);
      end else begin
        m_en = 1'b0;
      end
      if (p1_valid && !m_g1) m_streak++;
      else m_streak = 0;
      m_force = (m_streak >= SM);
    end
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 5'd3, 32'h1234, 1, 5'd4, 32'h5678);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b need 00",
               p0_ready, p1_ready);
    end
    checks++;
    if (rf_wr_en !== 1'b0 || rf_rd !== 5'd0 ||
        rf_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_regs: got en=%b rd=%0d d=%h need 0",
               rf_wr_en, rf_rd, rf_wr_data);
    end
    rst = 1'b0;
    drive(1, 5'd3, 32'h1234, 0, 0, 0);
    checks++;
    if (p0_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: got %b need 1", p0_ready);
    end
    tick();
    checks++;
    if (rf_wr_en !== 1'b1 || rf_rd !== 5'd3 ||
        rf_wr_data !== 32'h1234) begin
      errors++;
      $display("FAIL first_write: got en=%b rd=%0d d=%h",
               rf_wr_en, rf_rd, rf_wr_data);
    end
    idle();
  endtask

  task automatic test_p0_only();
    logic [XL-1:0] d [3];
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd5, d[i], 0, 0, 0);
      checks++;
      if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
        errors++;
        $display("FAIL p0only_ready[%0d]: got %b%b need 10",
                 i, p0_ready, p1_ready);
      end
      tick();
      checks++;
      if (rf_wr_en !== 1'b1 || rf_rd !== 5'd5 ||
          rf_wr_data !== d[i]) begin
        errors++;
        $display("FAIL p0only_wr[%0d]: got en=%b rd=%0d d=%h need 1/5/%h",
                 i, rf_wr_en, rf_rd, rf_wr_data, d[i]);
      end
    end
    idle();
    checks++;
    if (rf_wr_en !== 1'b0 || rf_rd !== 5'd5 ||
        rf_wr_data !== 32'h33) begin
      errors++;
      $display("FAIL idle_hold: got en=%b rd=%0d d=%h need 0/5/33",
               rf_wr_en, rf_rd, rf_wr_data);
    end
  endtask

  task automatic test_starve();
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'd3, XL'(100 + i), 1, 5'd7, XL'(200 + i));
      checks++;
      if (p1_ready !== (i == 4) || p0_ready !== (i != 4) ||
          p0_stall !== (i == 4)) begin
        errors++;
        $display("FAIL starve[%0d]: got p0r=%b p1r=%b st=%b",
                 i, p0_ready, p1_ready, p0_stall);
      end
      tick();
      checks++;
      if (rf_wr_en !== 1'b1 || rf_rd !== (i == 4 ? 5'd7 : 5'd3) ||
          rf_wr_data !== m_data) begin
        errors++;
        $display("FAIL starve_wr[%0d]: got rd=%0d d=%h need d=%h",
                 i, rf_rd, rf_wr_data, m_data);
      end
    end
    idle();
  endtask

  task automatic test_rd0();
    drive(0, 0, 0, 1, 5'd0, 32'hDEAD);
    checks++;
    if (p1_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd0_ready: got %b need 1", p1_ready);
    end
    tick();
    checks++;
    if (rf_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rd0_wr_en: got %b need 0", rf_wr_en);
    end
    idle();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd9, XL'(i + 1), 1, 5'd10, 32'hF0);
      tick();
    end
    drive(1, 5'd9, 32'h77, 1, 5'd10, 32'hF0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rf_wr_en !== 1'b0 || rf_rd !== 5'd0 ||
        rf_wr_data !== '0 || p0_ready !== 1'b0 ||
        p1_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got en=%b rd=%0d d=%h r=%b%b",
               rf_wr_en, rf_rd, rf_wr_data, p0_ready, p1_ready);
    end
    model_reset();
    rst = 1'b0;
    drive(1, 5'd9, 32'h77, 1, 5'd10, 32'hF0);
    checks++;
    if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_prio: got %b%b need 10",
               p0_ready, p1_ready);
    end
    tick();
    checks++;
    if (rf_wr_en !== 1'b1 || rf_rd !== 5'd9 ||
        rf_wr_data !== 32'h77) begin
      errors++;
      $display("FAIL post_rst_wr: got en=%b rd=%0d d=%h",
               rf_wr_en, rf_rd, rf_wr_data);
    end
    idle();
  endtask

  task automatic test_drop();
    int first;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd2, XL'(i), 1, 5'd12, 32'hAB);
      tick();
    end
    drive(1, 5'd2, 32'h5, 0, 0, 0);
    tick();
    first = -1;
    for (int i = 0; i < 10 && first < 0; i++) begin
      drive(1, 5'd2, XL'(i), 1, 5'd12, 32'hAB);
      checks++;
      if (p1_ready !== m_g1) begin
        errors++;
        $display("FAIL drop_ready[%0d]: got %b need %b",
                 i, p1_ready, m_g1);
      end
      if (p1_ready === 1'b1) first = i;
      tick();
    end
    checks++;
    if (first != SM) begin
      errors++;
      $display("FAIL drop_force_cycle: got %0d need %0d",
               first, SM);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [4:0]    q_rd [$];
    logic [XL-1:0] q_d  [$];
    logic [4:0]    e_rd;
    logic [XL-1:0] e_d;
    for (int k = 1; k <= 8; k++) begin
      if (k % 2 == 1)
        drive(1, 5'(k), XL'(k * 32'h101), 0, 0, 0);
      else
        drive(0, 0, 0, 1, 5'(k), XL'(k * 32'h101));
      checks++;
      if ((k % 2 == 1 && p0_ready !== 1'b1) ||
          (k % 2 == 0 && p1_ready !== 1'b1)) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b%b",
                 k, p0_ready, p1_ready);
      end
      q_rd.push_back(5'(k));
      q_d.push_back(XL'(k * 32'h101));
      tick();
      e_rd = q_rd.pop_front();
      e_d  = q_d.pop_front();
      checks++;
      if (rf_wr_en !== 1'b1 || rf_rd !== e_rd ||
          rf_wr_data !== e_d) begin
        errors++;
        $display("FAIL b2b_wr[%0d]: got en=%b rd=%0d d=%h need rd=%0d d=%h",
                 k, rf_wr_en, rf_rd, rf_wr_data, e_rd, e_d);
      end
    end
    idle();
    checks++;
    if (rf_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_extra: got en=%b need 0", rf_wr_en);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom),
            XL'($urandom),
            ($urandom_range(0, 2) != 0), 5'($urandom),
            XL'($urandom));
      checks++;
      if (p0_ready !== m_g0 || p1_ready !== m_g1 ||
          p0_stall !== (p0_valid & ~m_g0)) begin
        errors++;
        $display("FAIL rnd_ready[%0d]: got %b%b st=%b need %b%b",
                 i, p0_ready, p1_ready, p0_stall, m_g0, m_g1);
      end
      tick();
      checks++;
      if (rf_wr_en !== m_en || rf_rd !== m_rd ||
          rf_wr_data !== m_data) begin
        errors++;
        $display("FAIL rnd_wr[%0d]: got %b/%0d/%h need %b/%0d/%h",
                 i, rf_wr_en, rf_rd, rf_wr_data,
                 m_en, m_rd, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_p0_only();
    test_starve();
    test_rd0();
    test_async_reset();
    test_drop();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
